// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the memory arbiter slice.
//   ADDR_W / DATA_W / BE_W : bus widths used by every port of the slice.
//   master_id_t            : 1-bit master identifier (M0 / M1), stored in the
//                            read-return FIFO to route returning data.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- one simple memory request/response channel.
//   master modport : drives addr, write_data, byte_enable, write_req, read_req;
//                    receives ready (request accepted this cycle), read_data,
//                    read_data_valid.
//   slave modport  : the mirror image.
// The arbiter uses two slave-side instances (one per master) and one
// master-side instance towards the memory.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [BE_W-1:0]   byte_enable;
  logic              write_req;
  logic              read_req;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;

  modport master (
    input  ready, read_data, read_data_valid,
    output addr, write_data, byte_enable, write_req, read_req
  );

  modport slave (
    output ready, read_data, read_data_valid,
    input  addr, write_data, byte_enable, write_req, read_req
  );

endinterface

// File: rtl/id_fifo.sv
// id_fifo -- small FIFO holding the ID of every outstanding read.
//   clk, reset_n : clock and asynchronous active-low reset (empties the FIFO).
//   push, push_data : enqueue one entry (ignored when full).
//   pop          : dequeue the head entry (ignored when empty).
//   head         : current head entry, combinational (zero-latency routing).
//   full, empty  : occupancy flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Simultaneous push and pop leave the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-master round-robin arbiter in front of one memory slave.
//   clk, reset_n : clock and asynchronous active-low reset.
//   m0, m1       : master channels (slave modport); mN.ready pulses on
//                  acceptance, read data is broadcast and mN.read_data_valid
//                  marks the owner.
//   slv          : memory channel (master modport); returns arrive in order.
//   error        : sticky, set by a read return with nothing outstanding.
// Parameter RETURN_DEPTH: maximum outstanding reads (power of two, 2..16).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int RETURN_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   m0,
  mem_arbiter_if.slave   m1,
  mem_arbiter_if.master  slv,
  output logic           error
);

  master_id_t        last_grant_reg;
  logic              error_reg;

  logic              pend0;
  logic              pend1;
  logic              grant_valid;
  master_id_t        grant_id;

  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_write_data;
  logic [BE_W-1:0]   g_byte_enable;
  logic              g_read;
  logic              g_write;

  logic              fifo_full;
  logic              fifo_empty;
  master_id_t        head_id;
  logic              accept;
  logic              push;
  logic              pop;

  // Round robin: on contention the master that did not win last time wins.
  always_comb begin
    pend0       = m0.write_req | m0.read_req;
    pend1       = m1.write_req | m1.read_req;
    grant_valid = pend0 | pend1;
    if (pend0 && pend1) grant_id = ~last_grant_reg;
    else if (pend1)     grant_id = M1;
    else                grant_id = M0;
  end

  // A request with both strobes high is treated as a read.
  always_comb begin
    g_addr        = '0;
    g_write_data  = '0;
    g_byte_enable = '0;
    g_read        = 1'b0;
    g_write       = 1'b0;
    if (grant_valid) begin
      if (grant_id == M0) begin
        g_addr        = m0.addr;
        g_write_data  = m0.write_data;
        g_byte_enable = m0.byte_enable;
        g_read        = m0.read_req;
        g_write       = m0.write_req & ~m0.read_req;
      end else begin
        g_addr        = m1.addr;
        g_write_data  = m1.write_data;
        g_byte_enable = m1.byte_enable;
        g_read        = m1.read_req;
        g_write       = m1.write_req & ~m1.read_req;
      end
    end
  end

  // A read is withheld from the slave while the return FIFO is full, even if
  // a return pops an entry in the same cycle.
  assign slv.addr        = g_addr;
  assign slv.write_data  = g_write_data;
  assign slv.byte_enable = g_byte_enable;
  assign slv.write_req   = g_write;
  assign slv.read_req    = g_read & ~fifo_full;

  assign accept   = grant_valid & slv.ready & ~(g_read & fifo_full);
  assign m0.ready = accept & (grant_id == M0);
  assign m1.ready = accept & (grant_id == M1);

  assign push = accept & g_read;
  assign pop  = slv.read_data_valid & ~fifo_empty;

  // Returns route straight through; the FIFO head names the owner.
  assign m0.read_data       = slv.read_data;
  assign m1.read_data       = slv.read_data;
  assign m0.read_data_valid = pop & (head_id == M0);
  assign m1.read_data_valid = pop & (head_id == M1);

  assign error = error_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_reg <= M1;
      error_reg      <= 1'b0;
    end else begin
      if (accept) last_grant_reg <= grant_id;
      if (slv.read_data_valid && fifo_empty) error_reg <= 1'b1;
    end
  end

  id_fifo #(
    .DEPTH (RETURN_DEPTH),
    .WIDTH (1)
  ) u_id_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (grant_id),
    .pop       (pop),
    .head      (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- scoreboard bench for mem_arbiter.
// The stimulus task evaluates a transaction-level reference model (queue of
// outstanding read owners, last winner, sticky error) and pushes the expected
// bus view, acceptances and read returns into queues; a negedge monitor pops
// them whenever the DUT presents the corresponding output.
module tb_mem_arbiter;

  localparam int DEPTH = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        err;
  } bus_exp_t;

  typedef struct {
    logic        id;
    logic [31:0] addr;
  } acc_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } ret_t;

  logic clk;
  logic reset_n = 1'b1;
  logic error;

  mem_arbiter_if m0_if ();
  mem_arbiter_if m1_if ();
  mem_arbiter_if s_if ();

  mem_arbiter #(.RETURN_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .slv     (s_if),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus variables
  logic        m_rd [2];
  logic        m_wr [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd [2];
  logic [3:0]  m_be [2];
  logic        s_ready;
  logic        s_rdv;
  logic [31:0] s_rdata;
  bit          acc_flag [2];

  // Reference model state
  bit ids [$];
  int last_grant;
  bit err_m;

  bus_exp_t bus_q [$];
  acc_t     acc_q [$];
  ret_t     ret_q [$];

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    m0_if.read_req    = m_rd[0];
    m0_if.write_req   = m_wr[0];
    m0_if.addr        = m_addr[0];
    m0_if.write_data  = m_wd[0];
    m0_if.byte_enable = m_be[0];
    m1_if.read_req    = m_rd[1];
    m1_if.write_req   = m_wr[1];
    m1_if.addr        = m_addr[1];
    m1_if.write_data  = m_wd[1];
    m1_if.byte_enable = m_be[1];
    s_if.ready           = s_ready;
    s_if.read_data_valid = s_rdv;
    s_if.read_data       = s_rdata;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_wd[i] = '0; m_be[i] = '0;
    end
    s_ready = 1'b1; s_rdv = 1'b0; s_rdata = '0;
  endtask

  task automatic model_reset();
    ids.delete();
    last_grant = 1;
    err_m = 1'b0;
  endtask

  // One clock cycle: drive, predict, advance to just after the next posedge.
  task automatic step();
    int       win;
    bit       pend [2];
    bit       win_rd;
    bit       blocked;
    bit       acc;
    bus_exp_t b;
    apply_inputs();
    for (int i = 0; i < 2; i++) begin
      pend[i] = m_rd[i] | m_wr[i];
      acc_flag[i] = 1'b0;
    end
    if (pend[0] && pend[1]) win = 1 - last_grant;
    else if (pend[0])       win = 0;
    else if (pend[1])       win = 1;
    else                    win = -1;
    b = '{rd: 1'b0, wr: 1'b0, addr: '0, wd: '0, be: '0, err: err_m};
    acc = 1'b0;
    win_rd = 1'b0;
    if (win >= 0) begin
      win_rd  = m_rd[win];
      blocked = win_rd && (ids.size() == DEPTH);
      b.addr  = m_addr[win];
      b.wd    = m_wd[win];
      b.be    = m_be[win];
      b.rd    = win_rd && !blocked;
      b.wr    = !win_rd;
      acc     = s_ready && !blocked;
    end
    bus_q.push_back(b);
    if (acc) acc_q.push_back('{id: (win == 1), addr: m_addr[win]});
    if (s_rdv) begin
      if (ids.size() > 0) ret_q.push_back('{id: ids.pop_front(), data: s_rdata});
      else err_m = 1'b1;
    end
    if (acc) begin
      if (win_rd) ids.push_back(win == 1);
      last_grant = win;
      acc_flag[win] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: one bus record per driven cycle, acceptance and return records
  // consumed whenever the DUT raises the corresponding strobe.
  always @(negedge clk) begin
    bus_exp_t b;
    acc_t     a;
    ret_t     r;
    if (bus_q.size() > 0) begin
      b = bus_q.pop_front();
      chk1("slv_read_req", s_if.read_req, b.rd);
      chk1("slv_write_req", s_if.write_req, b.wr);
      chk32("slv_addr", s_if.addr, b.addr);
      chk32("slv_write_data", s_if.write_data, b.wd);
      chk32("slv_byte_enable", {28'd0, s_if.byte_enable}, {28'd0, b.be});
      chk1("error", error, b.err);
      if (m0_if.ready || m1_if.ready) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL accept unexpected m0_ready=%b m1_ready=%b required none", m0_if.ready, m1_if.ready);
        end else begin
          a = acc_q.pop_front();
          chk1("accept_m0_ready", m0_if.ready, ~a.id);
          chk1("accept_m1_ready", m1_if.ready, a.id);
          chk32("accept_addr", s_if.addr, a.addr);
        end
      end
      if (acc_q.size() > 0) begin
        checks++; errors++;
        $display("FAIL accept_missing actual=none required=m%0d", acc_q[0].id);
        acc_q.delete();
      end
      if (m0_if.read_data_valid || m1_if.read_data_valid) begin
        if (ret_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL return unexpected m0_rdv=%b m1_rdv=%b required none", m0_if.read_data_valid, m1_if.read_data_valid);
        end else begin
          r = ret_q.pop_front();
          chk1("return_m0_valid", m0_if.read_data_valid, ~r.id);
          chk1("return_m1_valid", m1_if.read_data_valid, r.id);
          chk32("return_m0_data", m0_if.read_data, r.data);
          chk32("return_m1_data", m1_if.read_data, r.data);
        end
      end
      if (ret_q.size() > 0) begin
        checks++; errors++;
        $display("FAIL return_missing actual=none required=m%0d data=%h", ret_q[0].id, ret_q[0].data);
        ret_q.delete();
      end
    end
  end

  task automatic do_reset();
    idle_inputs();
    apply_inputs();
    reset_n = 1'b0;
    #2;
    chk1("reset_error", error, 1'b0);
    chk1("reset_read_req", s_if.read_req, 1'b0);
    chk1("reset_write_req", s_if.write_req, 1'b0);
    chk1("reset_m0_ready", m0_if.ready, 1'b0);
    chk1("reset_m1_ready", m1_if.ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int k;
    idle_inputs();
    apply_inputs();
    model_reset();
    #1;
    do_reset();

    // Simultaneous reads after reset: m0 first, then m1.
    m_rd[0] = 1'b1; m_addr[0] = 32'h0000_0A00;
    m_rd[1] = 1'b1; m_addr[1] = 32'h0000_0B00;
    step();
    m_rd[0] = 1'b0; m_addr[0] = '0;
    step();
    m_rd[1] = 1'b0; m_addr[1] = '0;
    repeat (2) begin s_rdv = 1'b1; s_rdata = $urandom; step(); end
    s_rdv = 1'b0;

    // Single m0 read answered two cycles later.
    m_rd[0] = 1'b1; m_addr[0] = 32'h1000_0000;
    step();
    idle_inputs();
    step();
    s_rdv = 1'b1; s_rdata = 32'hDEAD_BEEF;
    step();
    s_rdv = 1'b0;

    // Fill the return FIFO from m1, then a fifth read waits for a return.
    m_rd[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_addr[1] = 32'h2000_0000 + 32'(i * 4);
      step();
    end
    m_addr[1] = 32'h2000_0010;
    repeat (3) step();
    s_rdv = 1'b1; s_rdata = 32'h1111_0000;
    step();
    s_rdv = 1'b0;
    step();
    m_rd[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rdv = 1'b1; s_rdata = 32'h1111_0001 + 32'(i);
      step();
    end
    s_rdv = 1'b0;

    // Push and pop together at count 2; routing order must survive.
    m_rd[0] = 1'b1; m_addr[0] = 32'h3000_0000; step(); m_rd[0] = 1'b0;
    m_rd[1] = 1'b1; m_addr[1] = 32'h3000_0004; step(); m_rd[1] = 1'b0;
    m_rd[0] = 1'b1; m_addr[0] = 32'h3000_0008; s_rdv = 1'b1; s_rdata = 32'hA0A0_0000; step();
    m_rd[0] = 1'b0;
    s_rdata = 32'hA0A0_0001; step();
    s_rdata = 32'hA0A0_0002; step();
    s_rdv = 1'b0;

    // Write held off by ready=0, then accepted.
    m_wr[0] = 1'b1; m_addr[0] = 32'h4000_0000; m_wd[0] = 32'h5555_AAAA; m_be[0] = 4'h3;
    s_ready = 1'b0;
    repeat (3) step();
    s_ready = 1'b1;
    step();
    idle_inputs();
    step();

    // Randomized traffic, requests held until accepted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_rd[i] && !m_wr[i] && $urandom_range(0, 99) < 50) begin
          k = $urandom_range(0, 9);
          m_rd[i]   = (k < 4) || (k >= 8);
          m_wr[i]   = (k >= 4);
          m_addr[i] = $urandom;
          m_wd[i]   = $urandom;
          m_be[i]   = 4'($urandom);
        end
      end
      s_ready = ($urandom_range(0, 99) < 70);
      s_rdv   = (ids.size() > 0) && ($urandom_range(0, 99) < 40);
      s_rdata = $urandom;
      step();
      for (int i = 0; i < 2; i++) begin
        if (acc_flag[i]) begin
          m_rd[i] = 1'b0; m_wr[i] = 1'b0;
        end
      end
    end
    idle_inputs();
    m_rd[0] = 1'b1; m_addr[0] = 32'h5000_0000;
    step();

    // Reset with reads outstanding; a later return must flag an error.
    do_reset();
    step();
    s_rdv = 1'b1; s_rdata = 32'hBAD0_0001;
    step();
    s_rdv = 1'b0;
    repeat (4) step();
    do_reset();
    repeat (2) step();

    chk32("scoreboard_drained", 32'(bus_q.size() + acc_q.size() + ret_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
